freq_counter: RTL and testbench

Upstream stage of the frequency meter. It measures the rate of an external square-wave input by counting its rising edges over a fixed gate window, then latches the result as 4-digit packed BCD. The display stage consumes `out[15:0]` directly. Range switch SW2 selects either a 1 s gate, which gives a reading in Hz up to 9999, or a 0.1 s gate, which gives a reading in units of 10 Hz up to 99.99 kHz.

---
 rtl/freq_meter_pkg.sv | 16 +
 rtl/bcd_counter4.sv | 61 ++++++
 rtl/freq_counter.sv | 104 ++++++++++
 tb/tb_freq_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM states and
// packed-BCD geometry used by the edge counter and the top level.
package freq_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   localparam int DIGIT_W = 4;
   localparam int NDIGITS = 4;
   localparam int BCD_W   = DIGIT_W * NDIGITS;

   localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed-BCD up-counter that saturates at 9999 with a sticky flag.
// count/sat are look-ahead values that already include this cycle's inc.
module bcd_counter4
   import freq_meter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] count,
   output logic             sat
);

   logic [BCD_W-1:0] cnt_q;
   logic             sat_q;
   logic [BCD_W-1:0] bumped;
   logic             hit;

   // Ripple-carry BCD increment; result MSB reports that 9999 was already reached.
   function automatic logic [BCD_W:0] sat_inc(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      if (v == BCD_MAX) begin
         return {1'b1, v};
      end
      for (int i = 0; i < NDIGITS; i++) begin
         if (carry) begin
            if (r[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
               r[i*DIGIT_W +: DIGIT_W] = 4'd0;
            end else begin
               r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return {1'b0, r};
   endfunction

   always_comb begin
      {hit, bumped} = sat_inc(cnt_q);
      count = cnt_q;
      sat   = sat_q;
      if (inc) begin
         count = bumped;
         sat   = sat_q | hit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= count;
         sat_q <= sat;
      end
   end

endmodule

// File: rtl/freq_counter.sv
// Gated rising-edge counter: counts sig_in edges over a 1 s or 0.1 s window
// (SW2) and latches the result as packed BCD with overflow and valid strobe.
module freq_counter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             SW2,
   output logic [BCD_W-1:0] out,
   output logic             ovf,
   output logic             valid
);

   localparam int TIMER_W = $clog2(CLK_HZ);
   localparam logic [TIMER_W-1:0] LAST_SLOW = TIMER_W'(CLK_HZ - 1);
   localparam logic [TIMER_W-1:0] LAST_FAST = TIMER_W'(CLK_HZ / 10 - 1);

   logic               sig_p0;
   logic               sig_p1;
   logic               sig_p2;
   logic               edge_p;
   logic               sw_q;
   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] gate_last;
   logic               range_chg;
   logic               win_end;
   logic               cnt_clr;
   logic               cnt_inc;
   logic [BCD_W-1:0]   count;
   logic               sat;

   // Stage p0/p1 resynchronise sig_in; p2 holds the previous level for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_p0 <= 1'b0;
         sig_p1 <= 1'b0;
         sig_p2 <= 1'b0;
      end else begin
         sig_p0 <= sig_in;
         sig_p1 <= sig_p0;
         sig_p2 <= sig_p1;
      end
   end

   assign edge_p    = sig_p1 & ~sig_p2;
   assign gate_last = sw_q ? LAST_FAST : LAST_SLOW;
   assign range_chg = (SW2 != sw_q);
   assign win_end   = (state == GATE) && (timer == gate_last) && !range_chg;
   assign cnt_clr   = (state == IDLE) || win_end;
   assign cnt_inc   = (state == GATE) && edge_p;

   bcd_counter4 u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (count),
      .sat   (sat)
   );

   // A range change overrides a coinciding window end so a mixed-gate count is never latched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         sw_q  <= SW2;
         out   <= '0;
         ovf   <= 1'b0;
         valid <= 1'b0;
      end else begin
         sw_q  <= SW2;
         valid <= win_end;
         if (range_chg) begin
            state <= IDLE;
            timer <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= GATE;
                  timer <= '0;
               end
               GATE: begin
                  if (timer == gate_last) begin
                     timer <= '0;
                     out   <= count;
                     ovf   <= sat;
                  end else begin
                     timer <= timer + TIMER_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  timer <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench for freq_counter: table of range/period vectors plus
// hand-written range-change, mid-window reset and overflow sequences.
module tb_freq_counter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sig_in;
   logic        SW2;
   logic [15:0] out;
   logic        ovf;
   logic        valid;

   logic        rst_b;
   logic        sig_b;
   logic        sw_b;
   logic [15:0] out_b;
   logic        ovf_b;
   logic        valid_b;

   freq_counter #(.CLK_HZ(1000)) dut (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .SW2    (SW2),
      .out    (out),
      .ovf    (ovf),
      .valid  (valid)
   );

   freq_counter #(.CLK_HZ(20000)) dut_big (
      .clk    (clk),
      .rst    (rst_b),
      .sig_in (sig_b),
      .SW2    (sw_b),
      .out    (out_b),
      .ovf    (ovf_b),
      .valid  (valid_b)
   );

   int checks = 0;
   int errors = 0;
   int per    = 2;
   int ph     = 0;
   int perb   = 2;
   int phb    = 0;
   bit big_done = 1'b0;

   typedef struct {
      logic        sw;
      int          per;
      logic [15:0] exp_out;
      int          gate;
   } vec_t;

   vec_t vecs[8];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Advance to the next falling edge and drive the next sig_in sample.
   task automatic step();
      @(negedge clk);
      if (per == 0) begin
         sig_in = 1'b0;
      end else begin
         sig_in = (ph < per / 2);
         ph = (ph + 1) % per;
      end
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!valid && n < budget);
      if (!valid) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no valid within %0d cycles", budget);
      end
   endtask

   task automatic big_wait(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         sig_b = (phb < perb / 2);
         phb = (phb + 1) % perb;
         n++;
      end while (!valid_b && n < budget);
      if (!valid_b) begin
         checks++;
         errors++;
         $display("FAIL big_wait: no valid within %0d cycles", budget);
      end
   endtask

   // 20 kHz instance: 10000 edges in a 1 s gate saturate, then a 5 kHz input reads 5000.
   initial begin
      int n;
      rst_b = 1'b1;
      sw_b  = 1'b0;
      sig_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      sig_b = 1'b1;
      phb   = 1;
      perb  = 2;
      big_wait(21000, n);
      chk("big_sat_out", out_b, 16'h9999);
      chk("big_sat_ovf", ovf_b, 1'b1);
      perb = 4;
      phb  = 0;
      big_wait(21000, n);
      big_wait(21000, n);
      chk("big_next_out", out_b, 16'h5000);
      chk("big_next_ovf", ovf_b, 1'b0);
      chk("big_gap", n, 20000);
      big_done = 1'b1;
   end

   initial begin
      int n;
      int k;
      rst    = 1'b1;
      SW2    = 1'b0;
      sig_in = 1'b0;
      per    = 2;
      ph     = 0;

      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_out", out, 16'h0000);
         chk("rst_ovf", ovf, 1'b0);
         chk("rst_valid", valid, 1'b0);
      end
      rst = 1'b0;

      vecs[0] = '{1'b0, 4,  16'h0250, 1000};
      vecs[1] = '{1'b1, 4,  16'h0025, 100};
      vecs[2] = '{1'b0, 10, 16'h0100, 1000};
      vecs[3] = '{1'b1, 10, 16'h0010, 100};
      vecs[4] = '{1'b0, 5,  16'h0200, 1000};
      vecs[5] = '{1'b1, 5,  16'h0020, 100};
      vecs[6] = '{1'b0, 2,  16'h0500, 1000};
      vecs[7] = '{1'b1, 0,  16'h0000, 100};

      for (int i = 0; i < 8; i++) begin
         SW2 = vecs[i].sw;
         per = vecs[i].per;
         ph  = 0;
         wait_valid(2200, n);
         for (int w = 0; w < 2; w++) begin
            wait_valid(vecs[i].gate + 5, n);
            chk($sformatf("v%0d_out", i), out, vecs[i].exp_out);
            chk($sformatf("v%0d_ovf", i), ovf, 1'b0);
            chk($sformatf("v%0d_gap", i), n, vecs[i].gate);
         end
         step();
         chk($sformatf("v%0d_pulse", i), valid, 1'b0);
      end

      // Range flip halfway through a 1 s window.
      SW2 = 1'b0;
      per = 4;
      ph  = 0;
      wait_valid(2200, n);
      wait_valid(1100, n);
      chk("rc_pre_out", out, 16'h0250);
      repeat (499) step();
      SW2 = 1'b1;
      n = 0;
      do begin
         step();
         n++;
         if (n == 50) chk("rc_hold_out", out, 16'h0250);
      end while (!valid && n < 300);
      chk("rc_latency", n, 102);
      chk("rc_out", out, 16'h0025);
      chk("rc_ovf", ovf, 1'b0);

      // Reset at cycle 700 of a 1 s window.
      SW2 = 1'b0;
      wait_valid(2200, n);
      wait_valid(1100, n);
      chk("rm_pre_out", out, 16'h0250);
      repeat (699) step();
      rst = 1'b1;
      step();
      chk("rm_out", out, 16'h0000);
      chk("rm_ovf", ovf, 1'b0);
      chk("rm_valid", valid, 1'b0);
      per = 0;
      step();
      step();
      rst = 1'b0;
      per = 4;
      ph  = 0;
      wait_valid(1100, n);
      chk("rm_latency", n, 1001);
      chk("rm_after_out", out, 16'h0250);
      chk("rm_after_ovf", ovf, 1'b0);

      k = 0;
      while (!big_done && k < 80000) begin
         step();
         k++;
      end
      if (!big_done) begin
         checks++;
         errors++;
         $display("FAIL big_done: overflow sequence did not complete");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
